cp0_interrupt_unit: RTL and testbench

//  CP0 interrupt state for the 5-stage core. Synchronises three external IRQ lines,

---
 rtl/cp0_interrupt_unit_pkg.sv | 26 ++
 rtl/cp0_interrupt_unit_irq_sync_edge.sv | 26 ++
 rtl/cp0_interrupt_unit.sv | 107 ++++++++++
 tb/tb_cp0_interrupt_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_interrupt_unit_pkg.sv
// Shared constants and types for the CP0 interrupt unit: write-enable bit
// positions, IRQ count and the commit delay-line entry.
package cp0_interrupt_unit_pkg;

  localparam int CP0_IRQ_N      = 3;
  localparam int CP0_DATA_BIT   = 4;
  localparam int CP0_WEN_EPC    = 3;
  localparam int CP0_WEN_IRSCLR = 2;
  localparam int CP0_WEN_IE     = 1;
  localparam int CP0_WEN_IRSSET = 0;

  typedef struct packed {
    logic                    valid;
    logic [3:0]              en;
    logic [CP0_DATA_BIT-1:0] data;
  } cp0_wr_t;

  // Index of the highest set bit; 0 when the vector is empty (callers gate on |v).
  function automatic logic [1:0] top_idx(input logic [CP0_IRQ_N-1:0] v);
    top_idx = 2'd0;
    for (int i = 0; i < CP0_IRQ_N; i++) begin
      if (v[i]) top_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/cp0_interrupt_unit_irq_sync_edge.sv
// One IRQ line: multi-flop synchroniser followed by a single-cycle rising-edge pulse.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_raw,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], irq_raw};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/cp0_interrupt_unit.sv
// CP0 interrupt state: pending latch, priority vs. in-service set, IE/EPC,
// and the issue-to-commit delay line for control-unit CP0 writes.
module cp0_interrupt_unit
  import cp0_interrupt_unit_pkg::*;
#(
  parameter int PIPE_DEPTH  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int PC_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CP0_IRQ_N-1:0]    irq_in,
  input  logic                    int_ack,
  input  logic                    pipe_stall,
  input  logic [3:0]              cp0_w_en,
  input  logic [CP0_DATA_BIT-1:0] cp0_w_data,
  input  logic [PC_W-1:0]         epc_in,
  output logic                    int_req,   // "int" is a reserved word
  output logic [2:0]              ints,
  output logic [CP0_IRQ_N-1:0]    irs,
  output logic                    cp0_w_collision,
  output logic [PC_W-1:0]         epc_out,
  output logic                    ie
);

  logic [CP0_IRQ_N-1:0] edge_pulse;
  logic [CP0_IRQ_N-1:0] pending;
  logic [CP0_IRQ_N-1:0] ack_clr;
  logic [1:0]           win;
  logic [1:0]           irs_top;

  for (genvar i = 0; i < CP0_IRQ_N; i++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .irq_raw (irq_in[i]),
      .rise    (edge_pulse[i])
    );
  end

  assign win     = top_idx(pending);
  assign irs_top = top_idx(irs);
  assign int_req = ie & (|pending) & ((irs == '0) | (win > irs_top));
  assign ints    = (|pending) ? ({1'b0, win} + 3'd1) : 3'd0;

  always_comb begin
    ack_clr = '0;
    if (int_ack && (|pending)) ack_clr[win] = 1'b1;
  end

  // A new edge on the line being acked wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~ack_clr) | edge_pulse;
  end

  cp0_wr_t         slot     [PIPE_DEPTH];
  logic [PC_W-1:0] slot_epc [PIPE_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        slot[k]     <= '0;
        slot_epc[k] <= '0;
      end
    end else if (!pipe_stall) begin
      slot[0]     <= '{valid: (cp0_w_en != 4'd0), en: cp0_w_en, data: cp0_w_data};
      slot_epc[0] <= epc_in;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        slot[k]     <= slot[k-1];
        slot_epc[k] <= slot_epc[k-1];
      end
    end
  end

  always_comb begin
    cp0_w_collision = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) cp0_w_collision = cp0_w_collision | slot[k].valid;
  end

  cp0_wr_t              cw;
  logic                 commit;
  logic [CP0_IRQ_N-1:0] irs_nxt;

  assign cw     = slot[PIPE_DEPTH-1];
  assign commit = cw.valid & ~pipe_stall;

  // Clear is applied before set so one entry can replace the whole mask.
  always_comb begin
    irs_nxt = irs;
    if (cw.en[CP0_WEN_IRSCLR]) irs_nxt = irs_nxt & cw.data[3:1];
    if (cw.en[CP0_WEN_IRSSET]) irs_nxt = irs_nxt | cw.data[3:1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irs     <= '0;
      ie      <= 1'b1;
      epc_out <= '0;
    end else if (commit) begin
      irs <= irs_nxt;
      if (cw.en[CP0_WEN_IE])  ie      <= cw.data[0];
      if (cw.en[CP0_WEN_EPC]) epc_out <= slot_epc[PIPE_DEPTH-1];
    end
  end

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// Self-checking bench for cp0_interrupt_unit: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_cp0_interrupt_unit;

  localparam int PIPE = 2;
  localparam int SYNC = 2;
  localparam int PCW  = 32;

  logic           clk, rst;
  logic [2:0]     irq_in;
  logic           int_ack, pipe_stall;
  logic [3:0]     cp0_w_en, cp0_w_data;
  logic [PCW-1:0] epc_in;
  logic           int_req;
  logic [2:0]     ints;
  logic [2:0]     irs;
  logic           cp0_w_collision;
  logic [PCW-1:0] epc_out;
  logic           ie;

  cp0_interrupt_unit #(.PIPE_DEPTH(PIPE), .SYNC_STAGES(SYNC), .PC_W(PCW)) dut (
    .clk             (clk),
    .rst             (rst),
    .irq_in          (irq_in),
    .int_ack         (int_ack),
    .pipe_stall      (pipe_stall),
    .cp0_w_en        (cp0_w_en),
    .cp0_w_data      (cp0_w_data),
    .epc_in          (epc_in),
    .int_req         (int_req),
    .ints            (ints),
    .irs             (irs),
    .cp0_w_collision (cp0_w_collision),
    .epc_out         (epc_out),
    .ie              (ie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int             rem;
    logic [3:0]     en;
    logic [3:0]     data;
    logic [PCW-1:0] epc;
  } wr_t;

  logic [2:0]     m_pend, m_irs;
  logic           m_ie;
  logic [PCW-1:0] m_epc;
  logic [2:0]     m_hist[$];
  wr_t            m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 3'b000;
    m_irs  = 3'b000;
    m_ie   = 1'b1;
    m_epc  = '0;
    m_q.delete();
    m_hist.delete();
    for (int k = 0; k < SYNC + 2; k++) m_hist.push_back(3'b000);
  endtask

  function automatic void model_int(output logic mi, output logic [2:0] mints);
    int w, t;
    w = -1;
    t = -1;
    for (int i = 0; i < 3; i++) begin
      if (m_pend[i]) w = i;
      if (m_irs[i])  t = i;
    end
    mi    = m_ie && (w >= 0) && (w > t);
    mints = 3'(w + 1);
  endfunction

  task automatic model_commit(input wr_t e);
    if (e.en[2]) m_irs = m_irs & e.data[3:1];
    if (e.en[0]) m_irs = m_irs | e.data[3:1];
    if (e.en[1]) m_ie  = e.data[0];
    if (e.en[3]) m_epc = e.epc;
  endtask

  // Called right at the active edge, with the inputs that edge samples.
  task automatic model_edge();
    logic       mi;
    logic [2:0] mints, ev;
    wr_t        e;
    model_int(mi, mints);
    if (int_ack && mints != 0) m_pend[mints-1] = 1'b0;
    m_hist.push_front(irq_in);
    void'(m_hist.pop_back());
    ev     = m_hist[SYNC] & ~m_hist[SYNC+1];
    m_pend = m_pend | ev;
    if (!pipe_stall) begin
      for (int k = 0; k < m_q.size(); k++) m_q[k].rem--;
      while (m_q.size() > 0 && m_q[0].rem == 0) begin
        e = m_q.pop_front();
        model_commit(e);
      end
      if (cp0_w_en != 4'd0) m_q.push_back('{rem: PIPE, en: cp0_w_en, data: cp0_w_data, epc: epc_in});
    end
  endtask

  task automatic compare_all();
    logic       mi;
    logic [2:0] mints;
    model_int(mi, mints);
    check("int", int_req, mi);
    check("ints", ints, mints);
    check("irs", irs, m_irs);
    check("ie", ie, m_ie);
    check("collision", cp0_w_collision, m_q.size() != 0);
    check("epc", epc_out, m_epc);
  endtask

  task automatic step(input logic [2:0] irq, input logic ack, input logic [3:0] en,
                      input logic [3:0] data, input logic [PCW-1:0] epc, input logic stall);
    irq_in     = irq;
    int_ack    = ack;
    cp0_w_en   = en;
    cp0_w_data = data;
    epc_in     = epc;
    pipe_stall = stall;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input logic [2:0] irq, input int n);
    for (int k = 0; k < n; k++) step(irq, 1'b0, 4'd0, 4'd0, '0, 1'b0);
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_irs", irs, 3'b000);
    check("rst_ie", ie, 1'b1);
    check("rst_epc", epc_out, 32'h0);
    check("rst_coll", cp0_w_collision, 1'b0);
    @(posedge clk);
    #1;
    check("rst_coll_edge", cp0_w_collision, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic       mi;
    logic [2:0] mints, irq_r;
    logic [3:0] en_r;

    rst = 1'b1; irq_in = '0; int_ack = 0; pipe_stall = 0;
    cp0_w_en = '0; cp0_w_data = '0; epc_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Quiet after reset
    for (int k = 0; k < 20; k++) begin
      idle(3'b000, 1);
      check("quiet_int", int_req, 1'b0);
      check("quiet_coll", cp0_w_collision, 1'b0);
    end

    // Single IRQ, latency, then int write
    idle(3'b001, 2);
    check("lat_early_int", int_req, 1'b0);
    idle(3'b001, 1);
    check("lat_int", int_req, 1'b1);
    check("lat_ints", ints, 3'd1);
    step(3'b001, 1'b1, 4'b1011, 4'b0010, 32'h0000_0100, 1'b0);
    check("wr_coll0", cp0_w_collision, 1'b1);
    idle(3'b001, 1);
    check("wr_coll1", cp0_w_collision, 1'b1);
    idle(3'b001, 1);
    check("wr_coll2", cp0_w_collision, 1'b0);
    check("wr_irs", irs, 3'b001);
    check("wr_ie", ie, 1'b0);
    check("wr_epc", epc_out, 32'h100);

    // Nesting: preempt from irs=001, then blocked by irs=100 until eret
    step(3'b001, 1'b0, 4'b0010, 4'b0001, '0, 1'b0);
    idle(3'b001, 2);
    idle(3'b101, 3);
    check("pre_int", int_req, 1'b1);
    check("pre_ints", ints, 3'd3);
    step(3'b101, 1'b1, 4'b0101, 4'b1000, '0, 1'b0);
    idle(3'b101, 2);
    check("nest_irs", irs, 3'b100);
    idle(3'b111, 6);
    check("blk_int", int_req, 1'b0);
    check("blk_ints", ints, 3'd2);
    step(3'b111, 1'b0, 4'b0110, 4'b0111, '0, 1'b0);
    idle(3'b111, 2);
    check("eret_irs", irs, 3'b000);
    check("eret_int", int_req, 1'b1);
    check("eret_ints", ints, 3'd2);
    step(3'b111, 1'b1, 4'd0, 4'd0, '0, 1'b0);
    check("eret_ack", int_req, 1'b0);

    // Simultaneous rise on lines 1 and 2
    idle(3'b000, 4);
    idle(3'b110, 3);
    check("sim_ints3", ints, 3'd3);
    step(3'b110, 1'b1, 4'd0, 4'd0, '0, 1'b0);
    check("sim_ints2", ints, 3'd2);
    check("sim_int2", int_req, 1'b1);
    step(3'b110, 1'b1, 4'd0, 4'd0, '0, 1'b0);
    check("sim_none", ints, 3'd0);

    // Stalled commit; writes offered during the stall are dropped
    step(3'b000, 1'b0, 4'b1000, 4'd0, 32'hDEAD_BEEF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(3'b000, 1'b0, 4'b1000, 4'd0, 32'h0000_1111, 1'b1);
      check("stall_coll", cp0_w_collision, 1'b1);
      check("stall_epc", epc_out, 32'h100);
    end
    idle(3'b000, 1);
    check("unst1_epc", epc_out, 32'h100);
    idle(3'b000, 1);
    check("unst2_epc", epc_out, 32'hDEAD_BEEF);
    check("unst2_coll", cp0_w_collision, 1'b0);

    // Reset with an entry in flight
    step(3'b000, 1'b0, 4'b1011, 4'b1110, 32'h0000_CAFE, 1'b0);
    idle(3'b000, 1);
    mid_reset();
    idle(3'b000, 3);

    // Random traffic against the model
    irq_r = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(7) == 0) irq_r[b] = ~irq_r[b];
      en_r = ($urandom_range(3) == 0) ? 4'($urandom) : 4'd0;
      model_int(mi, mints);
      step(irq_r, mi & 1'($urandom), en_r, 4'($urandom), $urandom, $urandom_range(3) == 0);
      if ($urandom_range(699) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
